// File: rtl/wb_commit_pkg.sv
// Shared types and constants for the writeback/commit stage.
package wb_commit_pkg;
  typedef enum logic [1:0] {TLB_NONE = 2'd0, TLB_RD = 2'd1, TLB_WR = 2'd2, TLB_FILL = 2'd3} tlb_op_e;
  typedef enum logic [1:0] {LD_B = 2'd0, LD_H = 2'd1, LD_W = 2'd2, LD_D = 2'd3} ld_size_e;
  typedef enum logic {S_IDLE = 1'b0, S_RD_WAIT = 1'b1} wb_state_e;

  localparam logic [5:0] ECODE_NONE = 6'd0;

  // Maximal-length Fibonacci tap masks, indexed by LFSR width.
  function automatic logic [5:0] lfsr_taps(input int w);
    case (w)
      2:       lfsr_taps = 6'b000011;
      3:       lfsr_taps = 6'b000110;
      4:       lfsr_taps = 6'b001100;
      5:       lfsr_taps = 6'b010100;
      6:       lfsr_taps = 6'b110000;
      default: lfsr_taps = 6'b000011;
    endcase
  endfunction
endpackage

// File: rtl/wb_commit_stage_load_align.sv
// Combinational load lane select and zero/sign extension.
module wb_load_align
  import wb_commit_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFFW = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      size,
  input  logic            sign,
  input  logic [OFFW-1:0] off,
  output logic [XLEN-1:0] result
);
  logic [OFFW-1:0] aoff;
  logic [XLEN-1:0] sh;

  // Offset bits below the access size are dropped to keep the lane aligned.
  assign aoff = off & ~OFFW'((1 << size) - 1);
  assign sh   = data >> {aoff, 3'b000};

  always_comb begin
    result = sh;
    case (ld_size_e'(size))
      LD_B: result = sign ? XLEN'($signed(sh[7:0]))  : XLEN'(sh[7:0]);
      LD_H: result = sign ? XLEN'($signed(sh[15:0])) : XLEN'(sh[15:0]);
      LD_W: result = sign ? XLEN'($signed(sh[31:0])) : XLEN'(sh[31:0]);
      default: result = sh;
    endcase
  end
endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: GPR write, exception commit, TLB sequencing, retire count.
module wb_commit_stage
  import wb_commit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TLBNUM    = 16,
  parameter int FILL_MODE = 0,
  localparam int OFFW = $clog2(XLEN/8),
  localparam int IW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_result,
  input  logic [4:0]      in_dest,
  input  logic            in_gpr_we,
  input  logic            in_ld,
  input  logic [1:0]      in_ld_size,
  input  logic            in_ld_sign,
  input  logic [OFFW-1:0] in_ld_off,
  input  logic [XLEN-1:0] in_ld_data,
  input  logic [5:0]      in_ecode,
  input  logic            in_has_int,
  input  logic [1:0]      in_tlb_op,
  input  logic [IW-1:0]   csr_tlbidx_index,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            ex_valid,
  output logic [5:0]      ex_ecode,
  output logic [XLEN-1:0] ex_pc,
  output logic [IW-1:0]   tlb_r_index,
  output logic            tlbrd_csr_we,
  output logic            tlb_we,
  output logic [IW-1:0]   tlb_w_index,
  output logic [63:0]     retired
);
  localparam logic [IW-1:0] TAPS     = IW'(lfsr_taps(IW));
  localparam logic [IW-1:0] FILL_RST = (FILL_MODE != 0) ? IW'(1) : '0;

  logic            wb_valid;
  wb_state_e       state;
  logic [XLEN-1:0] pc_q, result_q, ld_data_q, ld_ext;
  logic [4:0]      dest_q;
  logic            gpr_we_q, ld_q, ld_sign_q, has_int_q;
  logic [1:0]      ld_size_q;
  logic [OFFW-1:0] ld_off_q;
  logic [5:0]      ecode_q;
  tlb_op_e         tlb_op_q;
  logic [IW-1:0]   fill_idx;
  logic            exc, commit, capture, retire, fill_adv;

  assign exc = (ecode_q != ECODE_NONE) || has_int_q;
  // A clean TLBRD holds in IDLE for one cycle and commits from RD_WAIT.
  assign commit = !reset && wb_valid &&
                  ((state == S_IDLE && !(tlb_op_q == TLB_RD && !exc)) || state == S_RD_WAIT);
  assign in_ready = reset || !wb_valid || commit;
  assign capture  = in_valid && in_ready;
  assign retire   = commit && !exc;
  assign fill_adv = retire && tlb_op_q == TLB_FILL;

  assign rf_we        = retire && gpr_we_q;
  assign rf_waddr     = dest_q;
  assign rf_wdata     = ld_q ? ld_ext : result_q;
  assign ex_valid     = commit && exc;
  assign ex_ecode     = (ex_valid && !has_int_q) ? ecode_q : ECODE_NONE;
  assign ex_pc        = ex_valid ? pc_q : '0;
  assign tlb_we       = retire && (tlb_op_q == TLB_WR || tlb_op_q == TLB_FILL);
  assign tlbrd_csr_we = !reset && state == S_RD_WAIT;
  assign tlb_r_index  = csr_tlbidx_index;
  assign tlb_w_index  = (tlb_op_q == TLB_FILL) ? fill_idx : csr_tlbidx_index;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .data(ld_data_q), .size(ld_size_q), .sign(ld_sign_q), .off(ld_off_q), .result(ld_ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      state    <= S_IDLE;
    end else begin
      if (capture)     wb_valid <= 1'b1;
      else if (commit) wb_valid <= 1'b0;
      case (state)
        S_IDLE:    if (wb_valid && tlb_op_q == TLB_RD && !exc) state <= S_RD_WAIT;
        S_RD_WAIT: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      pc_q      <= in_pc;
      result_q  <= in_result;
      dest_q    <= in_dest;
      gpr_we_q  <= in_gpr_we;
      ld_q      <= in_ld;
      ld_size_q <= in_ld_size;
      ld_sign_q <= in_ld_sign;
      ld_off_q  <= in_ld_off;
      ld_data_q <= in_ld_data;
      ecode_q   <= in_ecode;
      has_int_q <= in_has_int;
      tlb_op_q  <= tlb_op_e'(in_tlb_op);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_idx <= FILL_RST;
      retired  <= '0;
    end else begin
      if (retire) retired <= retired + 64'd1;
      if (fill_adv) begin
        if (FILL_MODE != 0) fill_idx <= {fill_idx[IW-2:0], ^(fill_idx & TAPS)};
        else                fill_idx <= fill_idx + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed self-checking bench for wb_commit_stage (counter and LFSR fill modes).
module tb_wb_commit_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc, in_result, in_ld_data;
  logic [4:0]  in_dest;
  logic        in_gpr_we, in_ld, in_ld_sign, in_has_int;
  logic [1:0]  in_ld_size, in_ld_off, in_tlb_op;
  logic [5:0]  in_ecode;
  logic [3:0]  csr_idx;

  logic        in_ready, rf_we, ex_valid, tlbrd_csr_we, tlb_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, ex_pc;
  logic [5:0]  ex_ecode;
  logic [3:0]  tlb_r_index, tlb_w_index;
  logic [63:0] retired;

  logic        in_ready1, rf_we1, ex_valid1, tlbrd_csr_we1, tlb_we1;
  logic [4:0]  rf_waddr1;
  logic [31:0] rf_wdata1, ex_pc1;
  logic [5:0]  ex_ecode1;
  logic [3:0]  tlb_r_index1, tlb_w_index1;
  logic [63:0] retired1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_commit_stage #(.XLEN(32), .TLBNUM(16), .FILL_MODE(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_result(in_result), .in_dest(in_dest), .in_gpr_we(in_gpr_we),
    .in_ld(in_ld), .in_ld_size(in_ld_size), .in_ld_sign(in_ld_sign), .in_ld_off(in_ld_off),
    .in_ld_data(in_ld_data), .in_ecode(in_ecode), .in_has_int(in_has_int),
    .in_tlb_op(in_tlb_op), .csr_tlbidx_index(csr_idx),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ex_valid(ex_valid), .ex_ecode(ex_ecode), .ex_pc(ex_pc),
    .tlb_r_index(tlb_r_index), .tlbrd_csr_we(tlbrd_csr_we), .tlb_we(tlb_we),
    .tlb_w_index(tlb_w_index), .retired(retired)
  );

  wb_commit_stage #(.XLEN(32), .TLBNUM(16), .FILL_MODE(1)) dut_lfsr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_pc(in_pc), .in_result(in_result), .in_dest(in_dest), .in_gpr_we(in_gpr_we),
    .in_ld(in_ld), .in_ld_size(in_ld_size), .in_ld_sign(in_ld_sign), .in_ld_off(in_ld_off),
    .in_ld_data(in_ld_data), .in_ecode(in_ecode), .in_has_int(in_has_int),
    .in_tlb_op(in_tlb_op), .csr_tlbidx_index(csr_idx),
    .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1),
    .ex_valid(ex_valid1), .ex_ecode(ex_ecode1), .ex_pc(ex_pc1),
    .tlb_r_index(tlb_r_index1), .tlbrd_csr_we(tlbrd_csr_we1), .tlb_we(tlb_we1),
    .tlb_w_index(tlb_w_index1), .retired(retired1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_valid = 0; in_pc = 32'h1000; in_result = 0; in_ld_data = 0; in_dest = 0;
    in_gpr_we = 0; in_ld = 0; in_ld_sign = 0; in_has_int = 0; in_ld_size = 0;
    in_ld_off = 0; in_tlb_op = 0; in_ecode = 0;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic sg,
                          input logic [1:0] off, input logic [31:0] exp);
    clr();
    in_valid = 1; in_gpr_we = 1; in_dest = 5'd3; in_ld = 1; in_ld_data = 32'h80F0_1234;
    in_ld_size = sz; in_ld_sign = sg; in_ld_off = off; in_result = 32'hDEAD_BEEF;
    tick();
    in_valid = 0;
    chk({tag, "_we"}, 64'(rf_we), 64'd1);
    chk({tag, "_data"}, 64'(rf_wdata), 64'(exp));
    tick();
  endtask

  // Expected LFSR fill indices for width 4, taps [3,2], seed 1.
  logic [3:0] lfsr_seq [15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                                4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};

  initial begin
    clr();
    csr_idx = 4'd0;
    reset = 1;
    tick(); tick();
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_tlb_we", 64'(tlb_we), 64'd0);
    chk("rst_tlbrd", 64'(tlbrd_csr_we), 64'd0);
    chk("rst_retired", retired, 64'd0);
    reset = 0;

    load_chk("ld_b_s", 2'd0, 1'b1, 2'd2, 32'hFFFF_FFF0);
    load_chk("ld_b_u", 2'd0, 1'b0, 2'd2, 32'h0000_00F0);
    load_chk("ld_h_s", 2'd1, 1'b1, 2'd3, 32'hFFFF_80F0);
    load_chk("ld_w",   2'd2, 1'b0, 2'd1, 32'h80F0_1234);
    chk("ld_retired", retired, 64'd4);

    // Back-to-back ADDs.
    clr();
    in_valid = 1; in_gpr_we = 1; in_dest = 5'd1;
    for (int i = 0; i < 3; i++) begin
      in_result = 32'd100 + 32'(i);
      tick();
      chk("b2b_we", 64'(rf_we), 64'd1);
      chk("b2b_data", 64'(rf_wdata), 64'd100 + 64'(i));
      chk("b2b_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 0;
    tick();
    chk("b2b_idle_we", 64'(rf_we), 64'd0);
    chk("b2b_retired", retired, 64'd7);

    // TLBRD followed by an ADD.
    clr();
    csr_idx = 4'd5;
    in_valid = 1; in_tlb_op = 2'd1;
    tick();
    chk("rd_r_index", 64'(tlb_r_index), 64'd5);
    chk("rd_c1_csr_we", 64'(tlbrd_csr_we), 64'd0);
    chk("rd_c1_ready", 64'(in_ready), 64'd0);
    clr();
    in_valid = 1; in_gpr_we = 1; in_dest = 5'd2; in_result = 32'd200;
    tick();
    chk("rd_c2_csr_we", 64'(tlbrd_csr_we), 64'd1);
    chk("rd_c2_ready", 64'(in_ready), 64'd1);
    chk("rd_c2_rf_we", 64'(rf_we), 64'd0);
    tick();
    in_valid = 0;
    chk("rd_c3_csr_we", 64'(tlbrd_csr_we), 64'd0);
    chk("rd_add_we", 64'(rf_we), 64'd1);
    chk("rd_add_data", 64'(rf_wdata), 64'd200);
    tick();
    chk("rd_retired", retired, 64'd9);

    // Exceptions.
    clr();
    in_valid = 1; in_ecode = 6'h08; in_gpr_we = 1; in_dest = 5'd4; in_pc = 32'h2000;
    tick();
    in_valid = 0;
    chk("exc_valid", 64'(ex_valid), 64'd1);
    chk("exc_ecode", 64'(ex_ecode), 64'h08);
    chk("exc_pc", 64'(ex_pc), 64'h2000);
    chk("exc_rf_we", 64'(rf_we), 64'd0);
    tick();
    clr();
    in_valid = 1; in_ecode = 6'h08; in_has_int = 1;
    tick();
    in_valid = 0;
    chk("int_valid", 64'(ex_valid), 64'd1);
    chk("int_ecode", 64'(ex_ecode), 64'd0);
    tick();
    clr();
    in_valid = 1; in_ecode = 6'h08; in_tlb_op = 2'd1;
    tick();
    in_valid = 0;
    chk("exrd_valid", 64'(ex_valid), 64'd1);
    chk("exrd_csr_we", 64'(tlbrd_csr_we), 64'd0);
    chk("exrd_ready", 64'(in_ready), 64'd1);
    tick();
    chk("exrd_csr_we2", 64'(tlbrd_csr_we), 64'd0);
    chk("exc_retired", retired, 64'd9);

    // TLBFILL index policies from a fresh reset.
    clr();
    reset = 1;
    tick();
    reset = 0;
    in_valid = 1; in_tlb_op = 2'd3;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("fill_we", 64'(tlb_we), 64'd1);
      chk("fill_cnt_idx", 64'(tlb_w_index), 64'(i % 16));
      chk("fill_lfsr_idx", 64'(tlb_w_index1), 64'(lfsr_seq[i % 15]));
    end
    in_ecode = 6'h08;
    tick();
    chk("fill_exc_we", 64'(tlb_we), 64'd0);
    chk("fill_exc_valid", 64'(ex_valid), 64'd1);
    in_ecode = 6'h00;
    tick();
    in_valid = 0;
    chk("fill_after_exc_cnt", 64'(tlb_w_index), 64'd1);
    chk("fill_after_exc_lfsr", 64'(tlb_w_index1), 64'(lfsr_seq[2]));
    tick();

    // Reset while in RD_WAIT.
    clr();
    in_valid = 1; in_tlb_op = 2'd1;
    tick();
    in_valid = 0;
    tick();
    chk("mid_rd_csr_we", 64'(tlbrd_csr_we), 64'd1);
    reset = 1;
    tick();
    chk("mid_rst_csr_we", 64'(tlbrd_csr_we), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    reset = 0;
    #1;
    chk("post_rst_csr_we", 64'(tlbrd_csr_we), 64'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_retired", retired, 64'd0);
    tick();
    chk("post_rst_csr_we2", 64'(tlbrd_csr_we), 64'd0);
    chk("post_rst_rf_we", 64'(rf_we), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
